count_sequencer: RTL and testbench
==================================

COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the count register width in bits.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port clear  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  a command is offered this cycle.
REQ-005 SHALL have port cmd_ready  output  1  the sequencer can accept a command this cycle.
REQ-006 SHALL have port cmd_dir  input  1  0 = count up, 1 = count down.
REQ-007 SHALL have port cmd_target  input  WIDTH  the count value at which the run stops.
REQ-008 SHALL have port pause  input  1  freezes a run in progress while high.
REQ-009 SHALL have port abort  input  1  terminates any run and returns to idle.
REQ-010 SHALL have port select  output  1  the latched direction of the current or last run.
REQ-011 SHALL have port count_value  output  WIDTH  the current count.
REQ-012 SHALL have port busy  output  1  high in RUN and HOLD.
REQ-013 SHALL have port done  output  1  one-cycle pulse on run completion.

Function
REQ-014 SHALL implement the states IDLE, RUN, HOLD and DONE.
REQ-015 SHALL drive cmd_ready high only in IDLE with clear low; a command SHALL be accepted on an edge where cmd_valid and cmd_ready are both high.
REQ-016 On acceptance, SHALL latch cmd_dir into select and cmd_target into an internal target register; count_value SHALL be unchanged on that edge.
REQ-017 On acceptance, SHALL go to DONE if cmd_target equals count_value (zero-step run), and to RUN otherwise.
REQ-018 In RUN with pause low, SHALL add 1 to count_value each edge when select=0 and subtract 1 when select=1, both modulo 2^WIDTH (15+1 -> 0, 0-1 -> 15).
REQ-019 On the RUN edge where the updated count equals the target, SHALL go to DONE.
REQ-020 Run latency: a run of d = (target - start) mod 2^WIDTH steps up, or (start - target) mod 2^WIDTH steps down, SHALL complete in d RUN edges; done SHALL be high in the cycle after the last step.
REQ-021 In RUN with pause high, SHALL go to HOLD on the next edge without changing the count; that edge is not a step.
REQ-022 In HOLD, SHALL keep count_value unchanged and SHALL return to RUN on the first edge with pause low; stepping SHALL resume on the edge after that.
REQ-023 SHALL assert done only in DONE, and SHALL go from DONE to IDLE unconditionally on the next edge.
REQ-024 SHALL ignore cmd_valid outside IDLE; no command SHALL be queued.
REQ-025 With abort high at an edge in RUN, HOLD or DONE, SHALL go to IDLE with count_value holding its pre-edge value, and SHALL not pulse done.
REQ-026 If abort and pause are high together, abort SHALL take priority.
REQ-027 In IDLE, a high abort SHALL block acceptance of a command on that edge.
REQ-028 SHALL derive all outputs from registered state only; there SHALL be no combinational path from any input to any output other than cmd_ready.

Reset
REQ-029 While clear is high, SHALL hold the state at IDLE, count_value=0, select=0, target=0, busy=0, done=0 and cmd_ready=0, regardless of clk.
REQ-030 Asserting clear during RUN or HOLD SHALL discard the run immediately, with no done pulse.
REQ-031 After clear deasserts, SHALL accept a command on the first following rising edge.

Structure
REQ-032 SHALL place the state enum typedef (IDLE, RUN, HOLD, DONE) and the direction constants (DIR_UP=0, DIR_DOWN=1) in a shared package count_seq_pkg.
REQ-033 SHALL implement the count register as one sub-module, updown_step, with ports clk, clear, en, dir and count_value, parameterised by WIDTH; the FSM SHALL drive en and dir.

Verification (WIDTH=4, 20 ns clock)
REQ-034 SHALL verify basic up-count: after reset, command dir=0, target=5 -> count steps 1..5 on consecutive edges, busy=1 throughout, one done pulse, then cmd_ready=1.
REQ-035 SHALL verify down-count with wrap: start at 2, command dir=1, target=14 -> count steps 1,0,15,14, select=1, done after 4 steps.
REQ-036 SHALL verify the zero-step run: start at 7, command target=7 -> DONE on the edge after acceptance, done pulses, count stays 7.
REQ-037 SHALL verify pause: pause high for 3 cycles mid-run (dir=0, 0->9) -> count frozen for 3 cycles, then resumes, and the total run reaches 9 with no lost or extra step.
REQ-038 SHALL verify abort: abort at count 4 of a 0->10 run -> IDLE, count stays 4, no done pulse; a later command (dir=0, target=6) completes in 2 steps.
REQ-039 SHALL verify reset mid-run: clear asserted between clock edges at count 3 -> count=0 and busy=0 immediately; cmd_valid held high during a run is not accepted until IDLE.

Source files
------------

// File: rtl/count_seq_pkg.sv
// Shared types and constants for the count sequencer.
package count_seq_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD,
      DONE
   } state_e;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/count_sequencer_updown_step.sv
// Modulo-2^WIDTH up/down count register; steps by one when enabled.
module updown_step
   import count_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             en,
   input  logic             dir,
   output logic [WIDTH-1:0] count_value
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   logic [WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en) begin
         count_d = (dir == DIR_DOWN) ? count_q - One : count_q + One;
      end
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_value = count_q;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven counter: runs the count to a target, with pause/hold and abort.
module count_sequencer
   import count_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [WIDTH-1:0] cmd_target,
   input  logic             pause,
   input  logic             abort,
   output logic             select,
   output logic [WIDTH-1:0] count_value,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] One = WIDTH'(1);

   state_e           state_q, state_d;
   logic             select_q, select_d;
   logic [WIDTH-1:0] target_q, target_d;
   logic             step_en;
   logic [WIDTH-1:0] next_count;

   assign next_count = (select_q == DIR_DOWN) ? count_value - One : count_value + One;

   always_comb begin
      state_d  = state_q;
      select_d = select_q;
      target_d = target_q;
      step_en  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // abort in IDLE blocks acceptance on this edge
            if (cmd_valid && !abort) begin
               select_d = cmd_dir;
               target_d = cmd_target;
               state_d  = (cmd_target == count_value) ? DONE : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (pause) begin
               state_d = HOLD;
            end else begin
               step_en = 1'b1;
               if (next_count == target_q) begin
                  state_d = DONE;
               end
            end
         end
         HOLD: begin
            if (abort) begin
               state_d = IDLE;
            end else if (!pause) begin
               state_d = RUN;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state_q  <= IDLE;
         select_q <= DIR_UP;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         target_q <= target_d;
      end
   end

   updown_step #(
      .WIDTH(WIDTH)
   ) u_step (
      .clk        (clk),
      .clear      (clear),
      .en         (step_en),
      .dir        (select_q),
      .count_value(count_value)
   );

   // clear is the only input allowed to reach an output combinationally
   assign cmd_ready = (state_q == IDLE) && !clear;
   assign select    = select_q;
   assign busy      = (state_q == RUN) || (state_q == HOLD);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a step-count model.
module tb_count_sequencer;

   logic       clk = 1'b0;
   logic       clear;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir;
   logic [3:0] cmd_target;
   logic       pause;
   logic       abort;
   logic       select;
   logic [3:0] count_value;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;
   int pulses = 0;

   // Model: run progress tracked as steps remaining rather than a target compare.
   localparam int MIdle = 0, MRun = 1, MHold = 2, MDone = 3;
   int   m_mode;
   int   m_count;
   int   m_left;
   logic m_dir;

   count_sequencer #(
      .WIDTH(4)
   ) dut (
      .clk        (clk),
      .clear      (clear),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir    (cmd_dir),
      .cmd_target (cmd_target),
      .pause      (pause),
      .abort      (abort),
      .select     (select),
      .count_value(count_value),
      .busy       (busy),
      .done       (done)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode  = MIdle;
      m_count = 0;
      m_left  = 0;
      m_dir   = 1'b0;
   endfunction

   function automatic void model_step(input logic v, input logic d, input int t, input logic p,
                                      input logic a, input logic c);
      if (c) begin
         model_reset();
         return;
      end
      case (m_mode)
         MIdle: begin
            if (v && !a) begin
               m_dir  = d;
               m_left = d ? (m_count - t + 16) % 16 : (t - m_count + 16) % 16;
               m_mode = (m_left == 0) ? MDone : MRun;
            end
         end
         MRun: begin
            if (a) m_mode = MIdle;
            else if (p) m_mode = MHold;
            else begin
               m_count = (m_count + (m_dir ? 15 : 1)) % 16;
               m_left--;
               if (m_left == 0) m_mode = MDone;
            end
         end
         MHold: begin
            if (a) m_mode = MIdle;
            else if (!p) m_mode = MRun;
         end
         default: m_mode = MIdle;
      endcase
   endfunction

   task automatic check_all();
      check_eq("cmd_ready", cmd_ready, (m_mode == MIdle) && !clear);
      check_eq("busy", busy, (m_mode == MRun) || (m_mode == MHold));
      check_eq("done", done, m_mode == MDone);
      check_eq("select", select, m_dir);
      check_eq("count", count_value, m_count);
      if (done) pulses++;
   endtask

   // Drive one cycle's inputs just after an edge; clear takes effect immediately.
   task automatic tick(input logic v, input logic d, input logic [3:0] t, input logic p,
                       input logic a, input logic c);
      cmd_valid  = v;
      cmd_dir    = d;
      cmd_target = t;
      pause      = p;
      abort      = a;
      clear      = c;
      if (c) begin
         #1;
         model_reset();
         check_all();
      end
      @(posedge clk);
      model_step(v, d, int'(t), p, a, c);
      #1;
      check_all();
   endtask

   task automatic idle_tick();
      tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Issue a command and expect completion after exactly n steps.
   task automatic run_cmd(input logic d, input logic [3:0] t, input int n);
      pulses = 0;
      tick(1'b1, d, t, 1'b0, 1'b0, 1'b0);
      repeat (n) idle_tick();
      check_eq("done_on_time", done, 1);
      idle_tick();
      check_eq("one_done_pulse", pulses, 1);
      check_eq("final_count", count_value, t);
      check_eq("ready_after", cmd_ready, 1);
   endtask

   initial begin
      int n;
      cmd_valid  = 1'b0;
      cmd_dir    = 1'b0;
      cmd_target = 4'd0;
      pause      = 1'b0;
      abort      = 1'b0;
      clear      = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      check_eq("reset_ready", cmd_ready, 0);
      check_eq("reset_count", count_value, 0);

      // basic up-count 0 -> 5
      pulses = 0;
      tick(1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         idle_tick();
         check_eq("up_step", count_value, i);
      end
      check_eq("up_done", done, 1);
      idle_tick();
      check_eq("up_pulses", pulses, 1);
      check_eq("up_ready", cmd_ready, 1);

      // down-count with wrap: 5 -> 2, then 2 -> 14
      run_cmd(1'b1, 4'd2, 3);
      run_cmd(1'b1, 4'd14, 4);
      check_eq("down_select", select, 1);

      // zero-step run at 7
      run_cmd(1'b0, 4'd7, 9);
      run_cmd(1'b0, 4'd7, 0);

      // pause mid-run 0 -> 9
      run_cmd(1'b0, 4'd0, 9);
      pulses = 0;
      tick(1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
      repeat (3) idle_tick();
      repeat (3) begin
         tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
         check_eq("paused_count", count_value, 3);
      end
      n = 3 + 3;
      while (!done && n < 40) begin
         idle_tick();
         n++;
      end
      check_eq("pause_cycles", n, 13);
      check_eq("pause_final", count_value, 9);
      idle_tick();
      check_eq("pause_pulses", pulses, 1);

      // abort at count 4 of 0 -> 10
      run_cmd(1'b0, 4'd0, 7);
      pulses = 0;
      tick(1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (count_value != 4'd4 && n < 20) begin
         idle_tick();
         n++;
      end
      check_eq("abort_reach4", n, 4);
      tick(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
      check_eq("abort_busy", busy, 0);
      check_eq("abort_count", count_value, 4);
      repeat (2) idle_tick();
      check_eq("abort_no_done", pulses, 0);
      run_cmd(1'b0, 4'd6, 2);

      // clear mid-run at count 3, cmd_valid held high throughout
      run_cmd(1'b0, 4'd0, 10);
      tick(1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
      check_eq("pre_clear_count", count_value, 3);
      pulses = 0;
      tick(1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 1'b1);
      check_eq("clear_count", count_value, 0);
      check_eq("clear_busy", busy, 0);
      tick(1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 1'b0);
      check_eq("accept_after_clear", busy, 1);
      repeat (2) idle_tick();
      check_eq("post_clear_done", done, 1);
      idle_tick();
      check_eq("post_clear_pulses", pulses, 1);

      // random traffic
      repeat (500) begin
         tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
              $urandom_range(0, 49) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
